// File: rtl/axilite_mm_bridge.sv
// axilite_mm_bridge: AXI-Lite slave to single-outstanding memory-mapped bridge
// with one-deep AW/W/AR holding registers, round-robin arbitration, window decode and timeout.
module axilite_mm_bridge #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                    WIN_LOG2       = 16,
    parameter int                    TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [2:0]              awprot,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [2:0]              arprot,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic                    mem_valid,
    output logic                    mem_write,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ready,
    input  logic                    mem_err
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, WR_ACC, RD_ACC, WR_RESP, RD_RESP} state_t;

    state_t                  state;
    logic                    rst_done, aw_held, w_held, ar_held, last_rd;
    logic [ADDR_WIDTH-1:0]   aw_addr, ar_addr;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [SW-1:0]           w_strb;
    logic [CW-1:0]           cnt;
    logic                    grant_wr, take_wr, take_rd, hit, timed_out, done, err;
    logic                    unused_ok;

    assign unused_ok = ^{awprot, arprot};
    assign awready   = rst_done & ~aw_held;
    assign wready    = rst_done & ~w_held;
    assign arready   = rst_done & ~ar_held;

    // A tie between a complete write and a read goes to whichever did not win last time
    always_comb begin
        grant_wr  = aw_held & w_held & (~ar_held | last_rd);
        take_wr   = state == IDLE && grant_wr;
        take_rd   = state == IDLE && ar_held && !grant_wr;
        hit       = (grant_wr ? aw_addr[ADDR_WIDTH-1:WIN_LOG2] : ar_addr[ADDR_WIDTH-1:WIN_LOG2])
                    == BASE_ADDR[ADDR_WIDTH-1:WIN_LOG2];
        timed_out = TIMEOUT_CYCLES != 0 && !mem_ready && cnt == CNT_LAST;
        done      = mem_ready || timed_out;
        err       = !mem_ready || mem_err;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_done <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            ar_held  <= 1'b0;
            aw_addr  <= '0;
            ar_addr  <= '0;
            w_data   <= '0;
            w_strb   <= '0;
        end else begin
            rst_done <= 1'b1;
            if (take_wr) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
            if (take_rd)
                ar_held <= 1'b0;
            if (awvalid && awready) begin
                aw_held <= 1'b1;
                aw_addr <= awaddr;
            end
            if (wvalid && wready) begin
                w_held <= 1'b1;
                w_data <= wdata;
                w_strb <= wstrb;
            end
            if (arvalid && arready) begin
                ar_held <= 1'b1;
                ar_addr <= araddr;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            last_rd   <= 1'b1;
            cnt       <= '0;
            bvalid    <= 1'b0;
            bresp     <= 2'b00;
            rvalid    <= 1'b0;
            rresp     <= 2'b00;
            rdata     <= '0;
            mem_valid <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_wr) begin
                        last_rd <= 1'b0;
                        if (hit) begin
                            state     <= WR_ACC;
                            cnt       <= '0;
                            mem_valid <= 1'b1;
                            mem_write <= 1'b1;
                            mem_addr  <= aw_addr;
                            mem_wdata <= w_data;
                            mem_wstrb <= w_strb;
                        end else begin
                            state  <= WR_RESP;
                            bvalid <= 1'b1;
                            bresp  <= 2'b11;
                        end
                    end else if (take_rd) begin
                        last_rd <= 1'b1;
                        if (hit) begin
                            state     <= RD_ACC;
                            cnt       <= '0;
                            mem_valid <= 1'b1;
                            mem_addr  <= ar_addr;
                        end else begin
                            state  <= RD_RESP;
                            rvalid <= 1'b1;
                            rresp  <= 2'b11;
                            rdata  <= '0;
                        end
                    end
                end
                WR_ACC, RD_ACC: begin
                    if (done) begin
                        mem_valid <= 1'b0;
                        mem_write <= 1'b0;
                        mem_wstrb <= '0;
                        if (state == WR_ACC) begin
                            state  <= WR_RESP;
                            bvalid <= 1'b1;
                            bresp  <= {err, 1'b0};
                        end else begin
                            state  <= RD_RESP;
                            rvalid <= 1'b1;
                            rresp  <= {err, 1'b0};
                            rdata  <= mem_ready ? mem_rdata : '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        state  <= IDLE;
                    end
                end
                RD_RESP: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axilite_mm_bridge.sv
// tb_axilite_mm_bridge: directed and randomized bench for axilite_mm_bridge against a
// transaction-level reference model with a byte-strobed memory image.
module tb_axilite_mm_bridge;
    logic        clk, resetn;
    logic [31:0] awaddr, araddr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb, mem_wstrb;
    logic [1:0]  bresp, rresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic        mem_valid, mem_write, mem_ready, mem_err;

    axilite_mm_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h0), .WIN_LOG2(16), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .resetn(resetn),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_valid(mem_valid), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Peripheral: a 16-word memory that the DUT really writes and reads
    logic [31:0] periph [16] = '{default: '0};
    assign mem_rdata = periph[mem_addr[5:2]];
    always @(posedge clk)
        if (mem_valid && mem_ready && mem_write)
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) periph[mem_addr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];

    // Reference model: pending requests, one transaction in service, expected memory image
    logic [31:0] mmem [16] = '{default: '0};
    logic        m_rst_done, m_awh, m_wh, m_arh, m_last_rd, m_wr;
    logic [31:0] m_aw_a, m_ar_a, m_wd, m_addr, m_data, m_rdata;
    logic [3:0]  m_ws, m_strb;
    logic [1:0]  m_resp;
    int          m_ph, m_stalls;
    logic        cap_aw, cap_w, cap_ar;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_rst_done = 0; m_awh = 0; m_wh = 0; m_arh = 0; m_last_rd = 1; m_wr = 0;
            m_ph = 0; m_stalls = 0; m_resp = 0; m_rdata = 0;
            m_aw_a = 0; m_ar_a = 0; m_wd = 0; m_ws = 0; m_addr = 0; m_data = 0; m_strb = 0;
        end else begin
            cap_aw = m_rst_done && !m_awh && awvalid;
            cap_w  = m_rst_done && !m_wh && wvalid;
            cap_ar = m_rst_done && !m_arh && arvalid;
            if (m_ph == 0) begin
                if (m_awh && m_wh && (!m_arh || m_last_rd)) begin
                    m_wr = 1; m_addr = m_aw_a; m_data = m_wd; m_strb = m_ws;
                    m_awh = 0; m_wh = 0; m_last_rd = 0; m_ph = 3;
                end else if (m_arh) begin
                    m_wr = 0; m_addr = m_ar_a; m_arh = 0; m_last_rd = 1; m_ph = 3;
                end
                if (m_ph == 3) begin
                    m_stalls = 0;
                    if (m_addr[31:16] == 16'h0) m_ph = 1;
                    else begin m_ph = 2; m_resp = 2'b11; m_rdata = 0; end
                end
            end else if (m_ph == 1) begin
                if (mem_ready) begin
                    m_resp = mem_err ? 2'b10 : 2'b00;
                    if (m_wr) begin
                        for (int b = 0; b < 4; b++)
                            if (m_strb[b]) mmem[m_addr[5:2]][8*b +: 8] = m_data[8*b +: 8];
                    end else m_rdata = mmem[m_addr[5:2]];
                    m_ph = 2;
                end else begin
                    m_stalls++;
                    if (m_stalls == 4) begin m_ph = 2; m_resp = 2'b10; m_rdata = 0; end
                end
            end else if (m_ph == 2 && (m_wr ? bready : rready)) m_ph = 0;
            if (cap_aw) begin m_awh = 1; m_aw_a = awaddr; end
            if (cap_w) begin m_wh = 1; m_wd = wdata; m_ws = wstrb; end
            if (cap_ar) begin m_arh = 1; m_ar_a = araddr; end
            m_rst_done = 1;
        end
    end

    int          errors = 0, checks = 0;
    logic [3:0]  glog = '0;
    logic        mv_prev = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: step to the falling edge, compare every output with the model, log grants
    task automatic tick();
        @(negedge clk);
        chk("awready", awready, m_rst_done && !m_awh);
        chk("wready", wready, m_rst_done && !m_wh);
        chk("arready", arready, m_rst_done && !m_arh);
        chk("mem_valid", mem_valid, m_ph == 1);
        chk("mem_write", mem_write, m_ph == 1 && m_wr);
        chk("mem_wstrb", mem_wstrb, (m_ph == 1 && m_wr) ? m_strb : 4'h0);
        if (m_ph == 1) begin
            chk("mem_addr", mem_addr, m_addr);
            if (m_wr) chk("mem_wdata", mem_wdata, m_data);
        end
        chk("bvalid", bvalid, m_ph == 2 && m_wr);
        chk("rvalid", rvalid, m_ph == 2 && !m_wr);
        if (m_ph == 2 && m_wr) chk("bresp", bresp, m_resp);
        if (m_ph == 2 && !m_wr) begin
            chk("rresp", rresp, m_resp);
            chk("rdata", rdata, m_rdata);
        end
        if (mem_valid && !mv_prev) glog = {glog[2:0], mem_write};
        mv_prev = mem_valid;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] o;
        int r;
        o = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
        r = $urandom_range(0, 7);
        return r == 0 ? (32'h0001_0000 | o) : r == 1 ? (32'hFFFF_0000 | o) : o;
    endfunction

    int          nmv;
    logic        got, stall;
    logic [1:0]  r;
    logic [31:0] d;

    initial begin
        resetn = 1; awvalid = 0; wvalid = 0; arvalid = 0; awaddr = 0; araddr = 0;
        wdata = 0; wstrb = 0; awprot = 0; arprot = 0; bready = 1; rready = 1;
        mem_ready = 1; mem_err = 0; stall = 0;
        #1 resetn = 0;
        tick(); tick();
        chk("rst_awready", awready, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wstrb", mem_wstrb, 0);
        resetn = 1;
        tick(); tick();

        // Same-cycle AW+W write
        awvalid = 1; awaddr = 32'h10; wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        tick(); awvalid = 0; wvalid = 0;
        chk("t1_mv_c1", mem_valid, 0);
        tick();
        chk("t1_mv_c2", mem_valid, 1);
        chk("t1_addr", mem_addr, 32'h10);
        chk("t1_wdata", mem_wdata, 32'hDEADBEEF);
        chk("t1_wstrb", mem_wstrb, 4'hF);
        chk("t1_write", mem_write, 1);
        tick();
        chk("t1_bvalid", bvalid, 1);
        chk("t1_bresp", bresp, 2'b00);
        tick();
        chk("t1_bvalid_done", bvalid, 0);

        // W three cycles ahead of AW
        wvalid = 1; wdata = 32'h12345678; wstrb = 4'b0011;
        tick(); wvalid = 0;
        chk("t2_wready_c1", wready, 0);
        tick();
        chk("t2_wready_c2", wready, 0);
        chk("t2_mv_c2", mem_valid, 0);
        tick();
        awvalid = 1; awaddr = 32'h20;
        tick(); awvalid = 0;
        chk("t2_mv_c4", mem_valid, 0);
        tick();
        chk("t2_mv_c5", mem_valid, 1);
        chk("t2_addr", mem_addr, 32'h20);
        chk("t2_wdata", mem_wdata, 32'h12345678);
        chk("t2_wstrb", mem_wstrb, 4'b0011);
        tick(); tick();

        // Out-of-window read
        arvalid = 1; araddr = 32'h0001_0000;
        tick(); arvalid = 0;
        chk("t3_mv_c1", mem_valid, 0);
        tick();
        chk("t3_mv_c2", mem_valid, 0);
        chk("t3_rvalid", rvalid, 1);
        chk("t3_rresp", rresp, 2'b11);
        chk("t3_rdata", rdata, 0);
        tick();

        // Two rounds of simultaneous write and read requests
        for (int k = 0; k < 2; k++) begin
            awvalid = 1; awaddr = 32'h30 + 32'(4 * k); wvalid = 1; wdata = 32'hA5A5A5A5 ^ 32'(k);
            wstrb = 4'hF; arvalid = 1; araddr = k == 0 ? 32'h10 : 32'h20;
            tick(); awvalid = 0; wvalid = 0; arvalid = 0;
            repeat (10) tick();
        end
        chk("t4_grant_order", glog, 4'b1010);

        // Response held stable under rready backpressure
        arvalid = 1; araddr = 32'h10; rready = 0;
        tick(); arvalid = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_rvalid", rvalid, 1);
            chk("t5_rdata", rdata, 32'hDEADBEEF);
            chk("t5_rresp", rresp, 2'b00);
        end
        rready = 1;
        tick();
        chk("t5_rvalid_done", rvalid, 0);

        // Timeout on a read
        mem_ready = 0; arvalid = 1; araddr = 32'h10; nmv = 0; got = 0; r = 0; d = 32'hFFFFFFFF;
        for (int i = 0; i < 12; i++) begin
            tick(); arvalid = 0;
            if (mem_valid) nmv++;
            if (rvalid && !got) begin got = 1; r = rresp; d = rdata; end
        end
        mem_ready = 1;
        chk("t6_mv_cycles", nmv, 4);
        chk("t6_got_rvalid", got, 1);
        chk("t6_rresp", r, 2'b10);
        chk("t6_rdata", d, 0);

        // Peripheral error on a read
        mem_err = 1; arvalid = 1; araddr = 32'h10; got = 0; r = 0;
        for (int i = 0; i < 8; i++) begin
            tick(); arvalid = 0;
            if (rvalid && !got) begin got = 1; r = rresp; end
        end
        mem_err = 0;
        chk("t7_got_rvalid", got, 1);
        chk("t7_rresp", r, 2'b10);

        // Reset while a write is in its access phase
        mem_ready = 0; awvalid = 1; awaddr = 32'h38; wvalid = 1; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        tick(); awvalid = 0; wvalid = 0;
        tick();
        chk("t8_mv_acc", mem_valid, 1);
        #2 resetn = 0;
        #1 chk("t8_mv_async", mem_valid, 0);
        chk("t8_awready_rst", awready, 0);
        tick();
        resetn = 1; mem_ready = 1; got = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bvalid) got = 1;
        end
        chk("t8_no_bvalid", got, 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            tick();
            if ($urandom_range(0, 39) == 0) stall = !stall;
            awvalid = $urandom_range(0, 2) == 0; awaddr = rand_addr();
            wvalid = $urandom_range(0, 2) == 0; wdata = $urandom; wstrb = 4'($urandom);
            arvalid = $urandom_range(0, 2) == 0; araddr = rand_addr();
            awprot = 3'($urandom); arprot = 3'($urandom);
            bready = 1'($urandom); rready = 1'($urandom);
            mem_ready = !stall && $urandom_range(0, 2) != 0;
            mem_err = $urandom_range(0, 7) == 0;
        end
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1; mem_ready = 1; mem_err = 0;
        repeat (30) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axilite_mm_bridge.md
Name: axilite_mm_bridge

Overview:
Parametrised AXI-Lite slave to simple memory-mapped bridge; successor to the single-FSM AXI-Lite adapter in front of the PicoRV32 accelerator interconnect.
- Decouples AW, W and AR with independent one-deep holding registers.
- Arbitrates read against write round-robin.
- Decodes an address window and bounds every peripheral access with a timeout.
- Returns OKAY / SLVERR / DECERR responses, held stable until the master accepts them.

Parameters:
- ADDR_WIDTH, 32, address width of AXI and mem sides.
- DATA_WIDTH, 32, data width; legal values are 32 or 64; strobe width is DATA_WIDTH/8.
- BASE_ADDR, 32'h0000_0000, window base; must be aligned to 2**WIN_LOG2.
- WIN_LOG2, 16, window size is 2**WIN_LOG2 bytes.
- TIMEOUT_CYCLES, 255, maximum mem_valid cycles without mem_ready; 0 disables the timeout.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- awaddr  in  ADDR_WIDTH  write address
- awprot  in  3  ignored
- awvalid  in  1  /  awready  out  1
- wdata  in  DATA_WIDTH  /  wstrb  in  DATA_WIDTH/8
- wvalid  in  1  /  wready  out  1
- bresp  out  2  /  bvalid  out  1  /  bready  in  1
- araddr  in  ADDR_WIDTH  /  arprot  in  3  ignored
- arvalid  in  1  /  arready  out  1
- rdata  out  DATA_WIDTH  /  rresp  out  2  /  rvalid  out  1  /  rready  in  1
- mem_addr  out  ADDR_WIDTH  /  mem_wdata  out  DATA_WIDTH  /  mem_wstrb  out  DATA_WIDTH/8
- mem_valid  out  1  /  mem_write  out  1 (1 = write)
- mem_rdata  in  DATA_WIDTH  /  mem_ready  in  1  /  mem_err  in  1 (qualified by mem_ready)

Behaviour:
- Reset (asynchronous, resetn low):
  - All holding registers are emptied and the FSM goes to IDLE.
  - bvalid, rvalid, mem_valid, mem_write are 0; mem_wstrb, bresp, rresp, rdata, mem_addr, mem_wdata are 0.
  - A rst_done flop resets to 0 and sets to 1 on the first clk edge after release.
- Ready outputs:
  - awready = rst_done & !aw_held; wready = rst_done & !w_held; arready = rst_done & !ar_held.
  - AW and W are accepted in either order or in the same cycle, in any FSM state.
  - aw_held and w_held clear on the edge that leaves IDLE for a write. ar_held clears on the edge that leaves IDLE for a read.
- FSM states: IDLE, WR_ACC, RD_ACC, WR_RESP, RD_RESP.
- IDLE:
  - wr_rdy = aw_held & w_held; rd_rdy = ar_held.
  - If both are ready, the grant goes opposite to last_grant, which resets to "read" so the first tie grants the write. Otherwise the one that is ready is granted. last_grant updates on every grant.
  - The granted address is decoded: in window iff addr[ADDR_WIDTH-1:WIN_LOG2] == BASE_ADDR[ADDR_WIDTH-1:WIN_LOG2].
  - Out of window: go directly to WR_RESP/RD_RESP with resp 2'b11 (DECERR), rdata 0; mem_valid is never asserted.
  - In window: go to WR_ACC/RD_ACC.
- WR_ACC:
  - mem_valid=1, mem_write=1, mem_addr=held awaddr, mem_wdata/mem_wstrb=held W.
  - On mem_ready: bresp = mem_err ? 2'b10 : 2'b00; go to WR_RESP.
- RD_ACC:
  - mem_valid=1, mem_write=0, mem_wstrb=0, mem_addr=held araddr.
  - On mem_ready: rdata<=mem_rdata; rresp = mem_err ? 2'b10 : 2'b00; go to RD_RESP.
- Timeout:
  - The counter clears on entry to an ACC state and increments each ACC cycle without mem_ready.
  - When count == TIMEOUT_CYCLES-1 and mem_ready is low, the next state is the RESP state with SLVERR; rdata=0 for reads. mem_valid deasserts on that edge.
  - The counter is $clog2(TIMEOUT_CYCLES+1) bits wide.
  - mem_ready is ignored outside ACC states.
- WR_RESP: bvalid=1 with bresp stable; on bready go to IDLE. RD_RESP: rvalid=1 with rdata/rresp stable; on rready go to IDLE.
- Outside ACC states: mem_valid=0, mem_write=0, mem_wstrb=0.
- Latency (mem_ready tied high):
  - AW and W handshakes at cycle 0 -> mem_valid at cycle 2 -> bvalid at cycle 3.
  - AR at cycle 0 -> rvalid at cycle 3.
- Exactly one memory transaction is in flight. New AW/W/AR may be captured during ACC/RESP states; they are serviced after returning to IDLE.
- Reset asserted mid-transaction drops mem_valid immediately; the pending transaction is discarded and no response is issued.

Test Plan:
- Write awaddr=0x0000_0010, wdata=0xDEADBEEF, wstrb=0xF in the same cycle; mem_ready high -> mem_valid at cycle 2 with those values, bvalid at cycle 3, bresp=00.
- W presented 3 cycles before AW -> wready drops after the W capture; the write issues only after AW capture; the data is unchanged.
- AW/W and AR all held at the same IDLE cycle, twice in succession -> grant order write, read, write, read; alternation verified.
- araddr=0x0001_0000 with WIN_LOG2=16, BASE=0 -> mem_valid never asserted, rresp=11, rdata=0.
- Read with mem_ready held low, TIMEOUT_CYCLES=4 -> mem_valid high exactly 4 cycles, then rvalid with rresp=10, rdata=0. Separately, mem_ready with mem_err=1 -> SLVERR.
- Hold rready low 5 cycles -> rvalid and rdata stable throughout. resetn pulsed low during WR_ACC -> mem_valid=0 asynchronously, no bvalid afterwards.
